seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Downstream consumer of the 2 ms divided clock.
- Time-multiplexes a 32-bit hex value onto an 8-digit common-anode 7-segment display. It steps one digit per divided-clock transition, giving 2 ms per digit and a 16 ms frame.
- New display data is double-buffered and committed only at frame boundaries, so the display never shows a mix of two values.
- Everything runs in the system clock domain; the divided clock is used only as a sampled step strobe.

Parameters:
- DIGITS, 8: number of digits scanned. Fixed at 8; the index is 3 bits.
- RST_VALUE, 32'h0000_0000: value shown after reset.

Ports:
- clk_in  input  1  system clock; every register in the block is clocked on its rising edge.
- rst_n  input  1  asynchronous, active-low reset. Asserting it clears all state immediately, independent of clk_in.
- scan_clk  input  1  divided clock, toggling every 2 ms. It is generated from clk_in, so no synchronizer is required.
- data_in  input  32  value to display. Digit i shows data_in[4i+3:4i]; digit 0 is the rightmost.
- data_load  input  1  single-cycle strobe that captures data_in into the pending buffer.
- digit_en  input  8  per-digit enable; bit i = 1 lights digit i.
- led_en  output  8  digit anode selects, active-low, one-hot-low while a digit is lit.
- led_seg  output  8  segment lines {dp,g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse when the digit index wraps from 7 to 0.

Behaviour:
- Reset values:
  - scan_q = 0, idx = 0.
  - disp_reg = RST_VALUE, pend_reg = 0, pend_vld = 0.
  - led_en = 8'hFF, led_seg = 8'hFF, frame_done = 0.
- Step detection:
  - scan_q registers scan_clk every cycle.
  - step = scan_clk XOR scan_q, so both rising and falling edges step.
  - Each transition of scan_clk produces exactly one step cycle.
- Index:
  - On a step, idx <= idx + 1, with 3-bit wrap from 7 to 0.
  - Otherwise idx holds.
- Frame wrap:
  - wrap = step AND idx == 7.
  - frame_done is registered and equals 1 in the cycle after the wrap cycle.
- Pending buffer:
  - data_load: pend_reg <= data_in and pend_vld <= 1.
  - A later load before a wrap overwrites pend_reg; the last load wins.
  - wrap with pend_vld = 1: disp_reg <= pend_reg and pend_vld <= 0.
  - wrap with pend_vld = 0: disp_reg holds.
- Simultaneous wrap and data_load:
  - disp_reg takes the OLD pend_reg, but only if pend_vld was 1.
  - pend_reg <= data_in and pend_vld stays or becomes 1, so the new value commits at the next wrap.
- Outputs (registered every cycle from the current idx, disp_reg and digit_en):
  - If digit_en[idx] = 1: led_en = ~(8'b1 << idx) and led_seg = HEX(disp_reg[4*idx+3 : 4*idx]).
  - If digit_en[idx] = 0: led_en = 8'hFF and led_seg = 8'hFF, and the index still advances.
- HEX table, dp always 1:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8.
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Latency:
  - scan_clk is sampled toggled at edge T.
  - idx updates at edge T+1.
  - led_en/led_seg show the new digit at edge T+2.
  - A digit_en or disp_reg change is reflected one edge later.
- Reset mid-operation:
  - All state returns to reset values asynchronously, and pend_vld is lost.
  - After release, the first scan_clk transition moves idx from 0 to 1.
  - If scan_clk is 1 at release, the cycle after release is itself a step, because scan_q = 0.
- scan_clk held static: no steps occur and the current digit stays lit indefinitely.

Test Plan:
- Reset, then digit_en = 8'hFF with scan_clk held at 0.
  - led_en = FE and led_seg = C0 (digit 0 showing "0").
  - After 8 toggles, idx is back at 0 and exactly one frame_done pulse has occurred.
- data_load with data_in = 32'h7654_3210 at mid-frame (idx = 3).
  - disp_reg is unchanged until the wrap.
  - At the next frame, digit 5 gives led_en = DF and led_seg = 92.
  - digit 7 gives led_en = 7F and led_seg = F8.
- Two loads within one frame: 32'h1111_1111, then 32'hAAAA_AAAA.
  - Only AAAA_AAAA is displayed after the wrap; every digit shows led_seg = 88.
- data_load of 32'hFFFF_FFFF in the same cycle as the wrap, with pend_vld = 0.
  - The display is unchanged during the next frame.
  - F (led_seg = 8E) appears from the following frame onward.
- digit_en = 8'b0000_0101.
  - Only digits 0 and 2 light; led_en = FE and FB.
  - led_en = FF and led_seg = FF in the other six slots.
  - The frame is still 8 steps long.
- Assert rst_n mid-frame at idx = 5 with pend_vld = 1.
  - Outputs are immediately FF/FF and idx = 0.
  - The pending value is never displayed.
  - Releasing reset with scan_clk = 1 yields idx = 1 two cycles later.

Source files
------------

// File: rtl/seg7_scan.sv
// seg7_scan: scans a 32-bit hex value across an 8-digit common-anode
// 7-segment display, one digit per transition of the divided scan clock.
// New data is held in a pending buffer and committed only on frame wrap.
module seg7_scan #(
  parameter int          DIGITS    = 8,
  parameter logic [31:0] RST_VALUE = 32'h0000_0000
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                scan_clk,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic                data_load,
  input  logic [DIGITS-1:0]   digit_en,
  output logic [DIGITS-1:0]   led_en,
  output logic [7:0]          led_seg,
  output logic                frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  logic                scan_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [DIGITS-1:0]   led_en_q, led_en_d;
  logic [7:0]          led_seg_q, led_seg_d;
  logic                frame_done_q;

  logic                step, wrap;
  logic [3:0]          nib;

  // Both edges of the scan clock step the index; scan_q is the previous sample.
  assign step = scan_clk ^ scan_q;
  assign wrap = step && (idx_q == LAST);

  // Common-anode segment decode {dp,g,f,e,d,c,b,a}, active-low, dp off.
  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  // Next-state for index, double buffer and display outputs.
  always_comb begin
    idx_d      = idx_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    led_en_d   = '1;
    led_seg_d  = 8'hFF;
    nib        = 4'(disp_q >> {idx_q, 2'b00});

    if (step) idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;

    // Commit uses the old pending value; a same-cycle load refills the buffer
    // so it lands on the following wrap.
    if (wrap && pend_vld_q) begin
      disp_d     = pend_q;
      pend_vld_d = 1'b0;
    end
    if (data_load) begin
      pend_d     = data_in;
      pend_vld_d = 1'b1;
    end

    // Disabled digits blank their slot but the scan keeps its cadence.
    if (digit_en[idx_q]) begin
      led_en_d  = ~(DIGITS'(1) << idx_q);
      led_seg_d = hex7(nib);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      scan_q       <= 1'b0;
      idx_q        <= '0;
      disp_q       <= RST_VALUE[4*DIGITS-1:0];
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      led_en_q     <= '1;
      led_seg_q    <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      scan_q       <= scan_clk;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      led_en_q     <= led_en_d;
      led_seg_q    <= led_seg_d;
      frame_done_q <= wrap;
    end
  end

  assign led_en     = led_en_q;
  assign led_seg    = led_seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: scan cadence, frame pulse, double-buffered
// commits, digit enables and asynchronous reset mid-frame.
module tb_seg7_scan;

  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        scan_clk;
  logic [31:0] data_in;
  logic        data_load;
  logic [7:0]  digit_en;
  logic [7:0]  led_en;
  logic [7:0]  led_seg;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;
  int fd_base;

  logic [2:0]  bidx;   // expected digit index
  logic [31:0] shown;  // expected displayed value

  seg7_scan dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .scan_clk  (scan_clk),
    .data_in   (data_in),
    .data_load (data_load),
    .digit_en  (digit_en),
    .led_en    (led_en),
    .led_seg   (led_seg),
    .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  // Count frame pulses away from the active edge.
  always @(negedge clk_in) if (rst_n === 1'b1 && frame_done === 1'b1) fd_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_digit(input string tag, input logic [7:0] en_exp, input logic [7:0] seg_exp);
    chk8({tag, "_en"}, led_en, en_exp);
    chk8({tag, "_seg"}, led_seg, seg_exp);
  endtask

  // Expected outputs for the current index from the hand-set display value.
  task automatic chk_cur(input string tag);
    logic [7:0] en_e, seg_e;
    logic [31:0] sh;
    sh = shown >> (4 * bidx);
    en_e  = 8'hFF;
    seg_e = 8'hFF;
    if (digit_en[bidx]) begin
      en_e  = ~(8'h01 << bidx);
      seg_e = HEX[sh[3:0]];
    end
    chk_digit(tag, en_e, seg_e);
  endtask

  // One scan_clk transition, optionally with a load in the step cycle.
  task automatic do_step(input bit ld, input logic [31:0] v);
    bit wrapping;
    wrapping = (bidx == 3'd7);
    scan_clk = ~scan_clk;
    if (ld) begin
      data_in   = v;
      data_load = 1'b1;
    end
    tick();
    data_load = 1'b0;
    chk8("frame_done", {7'd0, frame_done}, {7'd0, wrapping});
    tick();
    chk8("frame_done_clr", {7'd0, frame_done}, 8'd0);
    bidx = bidx + 3'd1;
  endtask

  task automatic step();
    do_step(1'b0, 32'h0);
  endtask

  task automatic load(input logic [31:0] v);
    data_in   = v;
    data_load = 1'b1;
    tick();
    data_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; scan_clk = 1'b0; data_in = '0; data_load = 1'b0; digit_en = 8'hFF;
    bidx = 3'd0; shown = 32'h0;
    repeat (3) tick();
    chk_digit("rst", 8'hFF, 8'hFF);
    chk8("rst_fd", {7'd0, frame_done}, 8'd0);
    rst_n = 1'b1;
    tick();
    chk_digit("first", 8'hFE, 8'hC0);

    // Full frame of zeros; one frame pulse.
    for (int i = 0; i < 8; i++) begin
      step();
      chk_cur("frame1");
    end
    chk32("fd_frame1", fd_cnt, 1);

    // Load mid-frame at idx 3; display unchanged until wrap.
    repeat (3) step();
    load(32'h7654_3210);
    chk_cur("after_load");
    for (int i = 4; i < 8; i++) begin
      step();
      chk_cur("pre_wrap");
    end
    step();
    shown = 32'h7654_3210;
    chk_cur("commit0");
    for (int i = 1; i < 8; i++) begin
      step();
      chk_cur("frame2");
      if (i == 5) chk_digit("dig5", 8'hDF, 8'h92);
      if (i == 7) chk_digit("dig7", 8'h7F, 8'hF8);
    end

    // Two loads in one frame: last wins.
    step();
    load(32'h1111_1111);
    load(32'hAAAA_AAAA);
    chk_cur("two_load0");
    for (int i = 1; i < 8; i++) begin
      step();
      chk_cur("two_load");
    end
    step();
    shown = 32'hAAAA_AAAA;
    chk_digit("aaaa0", 8'hFE, 8'h88);
    for (int i = 1; i < 8; i++) begin
      step();
      chk8("aaaa_seg", led_seg, 8'h88);
    end

    // Load coinciding with wrap while nothing pending: lands one frame later.
    do_step(1'b1, 32'hFFFF_FFFF);
    chk_digit("coinc0", 8'hFE, 8'h88);
    for (int i = 1; i < 8; i++) begin
      step();
      chk_cur("coinc");
    end
    step();
    shown = 32'hFFFF_FFFF;
    chk_digit("ffff0", 8'hFE, 8'h8E);

    // Sparse enables: only digits 0 and 2 light, frame length unchanged.
    digit_en = 8'b0000_0101;
    tick();
    chk_cur("en0");
    fd_base = fd_cnt;
    for (int i = 1; i < 8; i++) begin
      step();
      chk_cur("sparse");
      if (i == 2) chk_digit("sparse2", 8'hFB, 8'h8E);
      if (i == 6) chk_digit("sparse6", 8'hFF, 8'hFF);
    end
    step();
    chk_digit("sparse_wrap", 8'hFE, 8'h8E);
    chk32("fd_sparse", fd_cnt, fd_base + 1);

    // Reset mid-frame at idx 5 with a pending value.
    digit_en = 8'hFF;
    tick();
    repeat (5) step();
    chk_digit("pre_rst5", 8'hDF, 8'h8E);
    load(32'h1234_5678);
    #2;
    rst_n = 1'b0;
    #1;
    chk_digit("async_rst", 8'hFF, 8'hFF);
    chk8("async_rst_fd", {7'd0, frame_done}, 8'd0);
    scan_clk = 1'b1;
    bidx = 3'd0;
    shown = 32'h0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk_digit("rel0", 8'hFE, 8'hC0);
    tick();
    chk_digit("rel1", 8'hFD, 8'hC0);
    bidx = 3'd1;
    repeat (20) tick();
    chk_digit("static", 8'hFD, 8'hC0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk_cur("post_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
